// File: rtl/ysyx_23060111_pkg.sv
// Shared constants for the writeback stage: load funct3 codes, FSM states
// and default datapath widths.
package ysyx_23060111_pkg;

   localparam int WBU_ADDR_WIDTH = 5;
   localparam int WBU_DATA_WIDTH = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WB   = 2'd3
   } wbu_state_e;

endpackage

// File: rtl/ysyx_23060111_load_ext.sv
// Combinational load extractor: selects the addressed byte/halfword/word
// from a read word and sign- or zero-extends it. Unknown funct3 acts as LW.
module ysyx_23060111_load_ext
   import ysyx_23060111_pkg::*;
#(
   parameter int DATA_WIDTH = WBU_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] word_i,
   input  logic [1:0]            addr_i,
   input  logic [2:0]            funct3_i,
   output logic [DATA_WIDTH-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      // addr_i[0] is deliberately ignored for halfwords
      half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = word_i;
      case (funct3_i)
         F3_LB:   data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LH:   data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         F3_LBU:  data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LHU:  data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         default: data_o = word_i;
      endcase
   end

endmodule

// File: rtl/ysyx_23060111_wbu.sv
// Load/writeback stage: accepts one retired instruction, performs the load
// read if needed, then writes the register file and pulses commit.
module ysyx_23060111_wbu
   import ysyx_23060111_pkg::*;
#(
   parameter int ADDR_WIDTH = WBU_ADDR_WIDTH,
   parameter int DATA_WIDTH = WBU_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0] in_result,
   input  logic                  in_is_load,
   input  logic [2:0]            in_funct3,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  commit
);

   wbu_state_e            state_q;
   logic [ADDR_WIDTH-1:0] rd_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic [2:0]            funct3_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] ext_data;

   ysyx_23060111_load_ext #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_load_ext (
      .word_i  (mem_resp_data),
      .addr_i  (result_q[1:0]),
      .funct3_i(funct3_q),
      .data_o  (ext_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         rd_q     <= '0;
         result_q <= '0;
         funct3_q <= '0;
         wdata_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  rd_q     <= in_rd;
                  result_q <= in_result;
                  funct3_q <= in_funct3;
                  if (in_is_load) begin
                     state_q <= S_REQ;
                  end else begin
                     wdata_q <= in_result;
                     state_q <= S_WB;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_ready) state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  wdata_q <= ext_data;
                  state_q <= S_WB;
               end
            end
            S_WB:    state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs decode the registered state; rst gates them so all read 0 in reset.
   always_comb begin
      in_ready      = (state_q == S_IDLE) && !rst;
      mem_req_valid = (state_q == S_REQ) && !rst;
      mem_req_addr  = mem_req_valid ? {result_q[DATA_WIDTH-1:2], 2'b00} : '0;
      commit        = (state_q == S_WB) && !rst;
      rf_wen        = commit && (rd_q != '0);
      rf_waddr      = commit ? rd_q : '0;
      rf_wdata      = commit ? wdata_q : '0;
   end

endmodule

// File: tb/tb_ysyx_23060111_wbu.sv
// Scoreboard bench for the writeback stage: stimulus queues expected register
// writes, a negedge monitor pops and compares on every commit.
module tb_ysyx_23060111_wbu;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic [31:0] in_result;
   logic        in_is_load;
   logic [2:0]  in_funct3;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        commit;

   typedef struct packed {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   wen_cnt  = 0;

   ysyx_23060111_wbu #(
      .ADDR_WIDTH(5),
      .DATA_WIDTH(32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rd         (in_rd),
      .in_result     (in_result),
      .in_is_load    (in_is_load),
      .in_funct3     (in_funct3),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .rf_wen        (rf_wen),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .commit        (commit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && (commit || rf_wen)) begin
         exp_t e;
         if (rf_wen) wen_cnt++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_commit: got commit=%0d rf_wen=%0d, required no writeback",
                     commit, rf_wen);
         end else begin
            e = exp_q.pop_front();
            check("commit", {31'b0, commit}, 32'd1);
            check("rf_wen", {31'b0, rf_wen}, {31'b0, e.wen});
            check("rf_waddr", {27'b0, rf_waddr}, {27'b0, e.waddr});
            check("rf_wdata", rf_wdata, e.wdata);
         end
      end
   end

   // Returns at the negedge of the cycle after acceptance.
   task automatic issue(input logic [4:0] rd, input logic [31:0] res, input logic ld,
                        input logic [2:0] f3, input logic [31:0] expv, input bit push);
      int unsigned t = 0;
      @(negedge clk);
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("in_ready_idle", {31'b0, in_ready}, 32'd1);
      in_valid   = 1'b1;
      in_rd      = rd;
      in_result  = res;
      in_is_load = ld;
      in_funct3  = f3;
      if (push) exp_q.push_back('{wen: (rd != 5'd0), waddr: rd, wdata: expv});
      @(negedge clk);
      in_valid   = 1'b0;
      in_rd      = '0;
      in_result  = '0;
      in_is_load = 1'b0;
      in_funct3  = '0;
   endtask

   task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input logic [31:0] expv,
                          input int req_wait, input int resp_wait, output int req_cycles);
      logic [31:0] exp_addr;
      exp_addr   = {addr[31:2], 2'b00};
      req_cycles = 0;
      issue(rd, addr, 1'b1, f3, expv, 1'b1);
      for (int i = 0; i < req_wait; i++) begin
         check("req_valid_held", {31'b0, mem_req_valid}, 32'd1);
         check("req_addr_held", mem_req_addr, exp_addr);
         check("in_ready_busy", {31'b0, in_ready}, 32'd0);
         if (mem_req_valid) req_cycles++;
         @(negedge clk);
      end
      check("req_valid", {31'b0, mem_req_valid}, 32'd1);
      check("req_addr", mem_req_addr, exp_addr);
      if (mem_req_valid) req_cycles++;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("req_dropped", {31'b0, mem_req_valid}, 32'd0);
      for (int i = 0; i < resp_wait; i++) begin
         check("in_ready_wait", {31'b0, in_ready}, 32'd0);
         @(negedge clk);
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = word;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("load_wb_latency", {31'b0, commit}, 32'd1);
   endtask

   localparam logic [31:0] W = 32'h8BAD_F00D;

   initial begin
      int rc;
      int wen_before;
      rst = 1'b1;
      in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0; in_funct3 = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
      check("rst_rf_wen", {31'b0, rf_wen}, 32'd0);
      check("rst_commit", {31'b0, commit}, 32'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // Non-load: write in the cycle after acceptance, ready again one cycle later
      issue(5'd5, 32'h1234_5678, 1'b0, 3'b000, 32'h1234_5678, 1'b1);
      check("alu_wb_latency", {31'b0, commit}, 32'd1);
      check("alu_in_ready_wb", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      check("alu_in_ready_after", {31'b0, in_ready}, 32'd1);

      do_load(5'd7,  32'h8000_0103, 3'b000, W, 32'hFFFF_FF8B, 0, 0, rc);
      do_load(5'd8,  32'h8000_0102, 3'b101, W, 32'h0000_8BAD, 0, 0, rc);
      do_load(5'd9,  32'h8000_0100, 3'b001, W, 32'hFFFF_F00D, 0, 0, rc);
      do_load(5'd10, 32'h8000_0101, 3'b100, W, 32'h0000_00F0, 0, 0, rc);
      do_load(5'd11, 32'h8000_0100, 3'b010, W, 32'h8BAD_F00D, 0, 0, rc);
      do_load(5'd12, 32'h8000_0103, 3'b001, W, 32'hFFFF_8BAD, 0, 0, rc);
      do_load(5'd13, 32'h8000_0101, 3'b000, W, 32'hFFFF_FFF0, 0, 0, rc);
      do_load(5'd14, 32'h8000_0102, 3'b100, W, 32'h0000_00AD, 0, 0, rc);
      do_load(5'd15, 32'h8000_0102, 3'b011, W, 32'h8BAD_F00D, 0, 0, rc);
      do_load(5'd16, 32'h8000_0101, 3'b111, W, 32'h8BAD_F00D, 0, 0, rc);

      // x0 destination: commit fires, no register write
      issue(5'd0, 32'hDEAD_BEEF, 1'b0, 3'b000, 32'hDEAD_BEEF, 1'b1);
      check("x0_commit", {31'b0, commit}, 32'd1);
      check("x0_rf_wen", {31'b0, rf_wen}, 32'd0);

      // Backpressure on both request and response
      @(negedge clk);
      wen_before = wen_cnt;
      do_load(5'd20, 32'h0000_1006, 3'b101, 32'hCAFE_0001, 32'h0000_CAFE, 3, 2, rc);
      check("bp_req_cycles", rc, 32'd4);
      @(negedge clk);
      check("bp_single_wen", wen_cnt - wen_before, 32'd1);

      // Reset while waiting for the response, then a stale response
      issue(5'd21, 32'h0000_2000, 1'b1, 3'b010, 32'h0, 1'b0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
      check("midrst_commit", {31'b0, commit}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'h5555_AAAA;
      #1;
      check("midrst_idle_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      check("stale_no_commit", {31'b0, commit}, 32'd0);
      check("stale_no_wen", {31'b0, rf_wen}, 32'd0);
      check("stale_in_ready", {31'b0, in_ready}, 32'd1);

      // Stage still works after the abandoned load
      issue(5'd3, 32'h0000_00AB, 1'b0, 3'b000, 32'h0000_00AB, 1'b1);
      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_23060111_wbu.md
Name: ysyx_23060111_wbu

Overview:
Load/writeback stage directly upstream of the register file. It accepts one retired instruction at a time from EXU over a valid/ready handshake. For loads it issues one word read to data memory, then extracts and extends the addressed byte, halfword or word. It drives the register file write port (wen/waddr/wdata) and a commit pulse, one instruction in flight at a time.

Parameters:
ADDR_WIDTH, 5, register index width (32 GPRs)
DATA_WIDTH, 32, datapath, memory-address and register width

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
in_valid  in  1  EXU has an instruction for writeback
in_ready  out  1  WBU can accept; high only in IDLE
in_rd  in  ADDR_WIDTH  destination register
in_result  in  DATA_WIDTH  ALU result; byte address when in_is_load
in_is_load  in  1  instruction is a load
in_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  DATA_WIDTH  word-aligned read address
mem_resp_valid  in  1  read data valid
mem_resp_data  in  DATA_WIDTH  read word
rf_wen  out  1  register file write enable
rf_waddr  out  ADDR_WIDTH  register file write index
rf_wdata  out  DATA_WIDTH  register file write data
commit  out  1  one-cycle pulse per retired instruction

Behaviour:
- FSM states: IDLE, REQ, WAIT, WB. Reset → IDLE.
- All outputs are 0 during reset, including in_ready. in_ready = (state==IDLE) && !rst.
- IDLE:
  - On in_valid&&in_ready, latch rd, result, funct3 and is_load.
  - Next state is REQ if is_load, else WB with wdata_q = result.
- REQ:
  - mem_req_valid=1; mem_req_addr = {result_q[31:2],2'b00}, held stable until accepted.
  - On mem_req_ready → WAIT.
- WAIT:
  - On mem_resp_valid, wdata_q = extend(mem_resp_data, result_q[1:0], funct3_q) → WB.
  - mem_resp_valid is ignored in every other state.
- Load extraction:
  - LB/LBU: byte at bits [8*a+7:8*a], where a = addr[1:0].
  - LH/LHU: halfword at bits [16*addr[1]+15:16*addr[1]]; addr[0] is ignored.
  - LW: full word; addr[1:0] ignored. Misaligned access is not supported and has no trap.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 values (011, 110, 111) are treated as LW.
- WB (exactly one cycle, then IDLE):
  - commit=1, rf_waddr=rd_q, rf_wdata=wdata_q.
  - rf_wen = (rd_q != 0), so x0 is never written; commit is still asserted for rd==0.
- Outputs rf_wen, rf_waddr, rf_wdata and commit are registered (decoded from state==WB with latched data). They are 0 in all other states.
- Latency, with instruction accepted in cycle N:
  - Non-load: rf_wen in cycle N+1.
  - Load with mem_req_ready already high: request in N+1, WAIT in N+2; if the response arrives in N+2, rf_wen in N+3.
- Throughput: at most one instruction every 2 cycles (non-load); no new acceptance until WB completes.
- Reset mid-operation: FSM returns to IDLE and any pending request is abandoned. A later stale mem_resp_valid is ignored, and neither rf_wen nor commit fires.
- Write timing: the register file samples waddr/wdata/wen on the same posedge that ends the WB cycle.

Decomposition:
- Package ysyx_23060111_pkg holds:
  - load funct3 localparams (LB, LH, LW, LBU, LHU)
  - FSM state encoding (2-bit)
  - default ADDR_WIDTH/DATA_WIDTH constants
- Sub-module ysyx_23060111_load_ext: purely combinational (word, addr[1:0], funct3) → extended DATA_WIDTH value. It is instantiated once in WAIT datapath and is unit-testable on its own.

Test Plan:
- Non-load: in_rd=5, in_result=0x12345678, mem idle → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x12345678, commit=1; in_ready back to 1 the cycle after.
- LB sign-extend: in_result=0x80000103, funct3=000, rd=7, mem word 0x8BADF00D → mem_req_addr=0x80000100, rf_wdata=0xFFFFFF8B, rf_waddr=7.
- Half/byte variants on same word 0x8BADF00D:
  - LHU @0x80000102 → 0x00008BAD
  - LH @0x80000100 → 0xFFFFF00D
  - LBU @0x80000101 → 0x000000F0
  - LW @0x80000100 → 0x8BADF00D
- rd=0 ALU op, result=0xDEADBEEF → commit=1, rf_wen=0 in WB cycle.
- Backpressure: load with mem_req_ready held low 3 cycles, then resp delayed 2 cycles → mem_req_valid high 4 cycles with constant addr; in_ready=0 throughout; exactly one rf_wen pulse.
- Reset in WAIT: assert rst 1 cycle, then drive mem_resp_valid=1 → state IDLE, in_ready=1, no rf_wen and no commit pulse.
